// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Purpose  : Forwarding and load-use hazard unit for a 5-stage MIPS pipeline.
//            Tracks the EX/MEM/WB destination registers and write/load flags,
//            drives the EX operand forwarding selects and raises a stall
//            for load-use hazards with a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0]       c_SEL_REGFILE = 2'b00;
    localparam logic [1:0]       c_SEL_EXMEM   = 2'b01;
    localparam logic [1:0]       c_SEL_MEMWB   = 2'b10;
    localparam logic [REG_W-1:0] c_ZERO_REG    = '0;
    localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;

    // EX-stage tracking
    logic [REG_W-1:0] r_ex_rs_q,      w_ex_rs_d;
    logic [REG_W-1:0] r_ex_rt_q,      w_ex_rt_d;
    logic             r_ex_uses_rs_q, w_ex_uses_rs_d;
    logic             r_ex_uses_rt_q, w_ex_uses_rt_d;
    logic [REG_W-1:0] r_ex_dest_q,    w_ex_dest_d;
    logic             r_ex_rw_q,      w_ex_rw_d;
    logic             r_ex_mr_q,      w_ex_mr_d;
    // MEM / WB tracking
    logic [REG_W-1:0] r_mem_dest_q,   w_mem_dest_d;
    logic             r_mem_rw_q,     w_mem_rw_d;
    logic [REG_W-1:0] r_wb_dest_q,    w_wb_dest_d;
    logic             r_wb_rw_q,      w_wb_rw_d;
    // stall statistics
    logic [CNT_W-1:0] r_stall_count_q, w_stall_count_d;

    logic w_stall;
    logic w_ex_load_id;

    // Selects the forwarding source for one EX operand; MEM beats WB because
    // it holds the younger producer, and $0 is never forwarded.
    function automatic logic [1:0] f_fwd_sel(
        input logic             uses,
        input logic [REG_W-1:0] src,
        input logic             mem_rw,
        input logic [REG_W-1:0] mem_dest,
        input logic             wb_rw,
        input logic [REG_W-1:0] wb_dest
    );
        logic [1:0] sel;
        sel = c_SEL_REGFILE;
        if (uses && mem_rw && (mem_dest != c_ZERO_REG) && (mem_dest == src)) begin
            sel = c_SEL_EXMEM;
        end else if (uses && wb_rw && (wb_dest != c_ZERO_REG) && (wb_dest == src)) begin
            sel = c_SEL_MEMWB;
        end
        return sel;
    endfunction

    // Load-use detection: a load in EX feeding a live, unflushed ID reader
    always_comb begin
        w_stall = id_valid && !flush && r_ex_mr_q && r_ex_rw_q &&
                  (r_ex_dest_q != c_ZERO_REG) &&
                  ((id_uses_rs && (r_ex_dest_q == id_rs)) ||
                   (id_uses_rt && (r_ex_dest_q == id_rt)));
    end

    // Next-state for the pipeline tracking registers and the stall counter
    always_comb begin
        w_ex_load_id    = id_valid && !w_stall && !flush;
        // a bubble carries all-zero fields so it can never match anything
        w_ex_rs_d       = w_ex_load_id ? id_rs        : c_ZERO_REG;
        w_ex_rt_d       = w_ex_load_id ? id_rt        : c_ZERO_REG;
        w_ex_uses_rs_d  = w_ex_load_id && id_uses_rs;
        w_ex_uses_rt_d  = w_ex_load_id && id_uses_rt;
        w_ex_dest_d     = w_ex_load_id ? id_dest      : c_ZERO_REG;
        w_ex_rw_d       = w_ex_load_id && id_reg_write;
        w_ex_mr_d       = w_ex_load_id && id_mem_read;
        w_mem_dest_d    = r_ex_dest_q;
        w_mem_rw_d      = r_ex_rw_q;
        w_wb_dest_d     = r_mem_dest_q;
        w_wb_rw_d       = r_mem_rw_q;
        w_stall_count_d = r_stall_count_q;
        if (w_stall && (r_stall_count_q != c_CNT_MAX)) begin
            w_stall_count_d = r_stall_count_q + 1'b1;
        end
    end

    // Pipeline tracking and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rs_q       <= c_ZERO_REG;
            r_ex_rt_q       <= c_ZERO_REG;
            r_ex_uses_rs_q  <= 1'b0;
            r_ex_uses_rt_q  <= 1'b0;
            r_ex_dest_q     <= c_ZERO_REG;
            r_ex_rw_q       <= 1'b0;
            r_ex_mr_q       <= 1'b0;
            r_mem_dest_q    <= c_ZERO_REG;
            r_mem_rw_q      <= 1'b0;
            r_wb_dest_q     <= c_ZERO_REG;
            r_wb_rw_q       <= 1'b0;
            r_stall_count_q <= '0;
        end else begin
            r_ex_rs_q       <= w_ex_rs_d;
            r_ex_rt_q       <= w_ex_rt_d;
            r_ex_uses_rs_q  <= w_ex_uses_rs_d;
            r_ex_uses_rt_q  <= w_ex_uses_rt_d;
            r_ex_dest_q     <= w_ex_dest_d;
            r_ex_rw_q       <= w_ex_rw_d;
            r_ex_mr_q       <= w_ex_mr_d;
            r_mem_dest_q    <= w_mem_dest_d;
            r_mem_rw_q      <= w_mem_rw_d;
            r_wb_dest_q     <= w_wb_dest_d;
            r_wb_rw_q       <= w_wb_rw_d;
            r_stall_count_q <= w_stall_count_d;
        end
    end

    // Operand forwarding selects, derived from the current EX/MEM/WB contents
    always_comb begin
        fwd_a_sel = f_fwd_sel(r_ex_uses_rs_q, r_ex_rs_q, r_mem_rw_q, r_mem_dest_q,
                              r_wb_rw_q, r_wb_dest_q);
        fwd_b_sel = f_fwd_sel(r_ex_uses_rt_q, r_ex_rt_q, r_mem_rw_q, r_mem_dest_q,
                              r_wb_rw_q, r_wb_dest_q);
    end

    assign stall       = w_stall;
    assign stall_count = r_stall_count_q;

endmodule
`default_nettype wire
